// File: rtl/serial_tx_defs_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding and default idle level.
package serial_tx_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/serial_tx_shiftreg.sv
// Load/shift register presenting the next frame bit at its head; optional captured-word parity.
// Parity output exists only when SERIAL_TX_PARITY_EN is defined.
module serial_tx_shiftreg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             head_o
`ifdef SERIAL_TX_PARITY_EN
    ,
    output logic             parity_o
`endif
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load has priority; shift direction moves the next bit into the head position.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end else begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign head_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

`ifdef SERIAL_TX_PARITY_EN
    logic parity_q;

    // Even parity of the whole word, frozen at load since the register drains while shifting.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            parity_q <= 1'b0;
        end else if (load_i) begin
            parity_q <= ^data_i;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: rtl/serial_word_tx.sv
// Moore serial word transmitter: valid/ready word intake, one bit per clock on serial_out.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_word_tx
    import serial_tx_defs::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load;
    logic             shift;
    logic             head;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity;
`endif

    serial_tx_shiftreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shiftreg (
        .clk      (clk),
        .reset_i  (reset),
        .load_i   (load),
        .shift_i  (shift),
        .data_i   (data_in),
        .head_o   (head)
`ifdef SERIAL_TX_PARITY_EN
        ,
        .parity_o (parity)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and shift-register control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_valid && data_ready) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: state_d = ST_DONE;
`endif
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state; unused encodings look idle on the line.
    always_comb begin
        serial_out = IDLE_LEVEL;
        bit_valid  = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                serial_out = head;
                bit_valid  = 1'b1;
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                serial_out = parity;
                bit_valid  = 1'b1;
            end
`endif
            default: begin
                serial_out = IDLE_LEVEL;
                bit_valid  = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign data_ready = (state_q == ST_IDLE) && !reset;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: directed frames on MSB-first and LSB-first instances plus a randomized run.
// Honours SERIAL_TX_PARITY_EN in its frame model.
module tb_serial_word_tx;

    localparam int unsigned W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned FL = W + PAR;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din_m, din_l;
    logic         valid_m, valid_l;
    logic         dr_m, so_m, bv_m, busy_m, done_m;
    logic         dr_l, so_l, bv_l, busy_l, done_l;

    int tests  = 0;
    int failed = 0;

    logic q_bits[$];
    logic exp_bits[$];
    logic [W-1:0] sent[$];
    bit   mon_en = 1'b0;
    int   mon_dones = 0;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .data_in(din_m), .data_valid(valid_m),
        .data_ready(dr_m), .serial_out(so_m), .bit_valid(bv_m), .busy(busy_m), .done(done_m)
    );

    serial_word_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(din_l), .data_valid(valid_l),
        .data_ready(dr_l), .serial_out(so_l), .bit_valid(bv_l), .busy(busy_l), .done(done_l)
    );

    // Passive monitor for the randomized run (MSB-first instance).
    always @(negedge clk) begin
        if (mon_en) begin
            if (bv_m) q_bits.push_back(so_m);
            if (done_m) mon_dones++;
        end
    end

    function automatic logic [4:0] obs(input bit sel);
        if (sel) return {so_l, bv_l, busy_l, done_l, dr_l};
        return {so_m, bv_m, busy_m, done_m, dr_m};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [W-1:0] d);
        if (sel) begin
            valid_l = v;
            din_l   = d;
        end else begin
            valid_m = v;
            din_m   = d;
        end
    endtask

    // Expected line bits of one frame: data bits in send order, then optional even parity.
    function automatic void push_frame(input logic [W-1:0] w, input bit msb);
        for (int i = 0; i < int'(W); i++) begin
            if (msb) exp_bits.push_back(w[W-1-i]);
            else     exp_bits.push_back(w[i]);
        end
        if (PAR != 0) exp_bits.push_back(^w);
    endfunction

    task automatic send_and_check(input bit sel, input logic [W-1:0] word, input string name);
        logic [4:0] e;
        logic [4:0] o;
        exp_bits.delete();
        push_frame(word, !sel);
        @(negedge clk);
        o = obs(sel);
        tests++;
        if (o !== 5'b00001) begin
            failed++;
            $display("FAIL %s idle-before: got %b want %b", name, o, 5'b00001);
        end
        drive(sel, 1'b1, word);
        @(negedge clk);
        for (int i = 0; i < int'(FL); i++) begin
            drive(sel, 1'b0, W'($urandom));
            o = obs(sel);
            e = {exp_bits[i], 4'b1100};
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL %s bit%0d: got %b want %b", name, i + 1, o, e);
            end
            @(negedge clk);
        end
        o = obs(sel);
        tests++;
        if (o !== 5'b00110) begin
            failed++;
            $display("FAIL %s done-cycle: got %b want %b", name, o, 5'b00110);
        end
        @(negedge clk);
        o = obs(sel);
        tests++;
        if (o !== 5'b00001) begin
            failed++;
            $display("FAIL %s ready-return: got %b want %b", name, o, 5'b00001);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        repeat (3) @(negedge clk);
        tests++;
        if ({obs(1'b0), obs(1'b1)} !== 10'b0) begin
            failed++;
            $display("FAIL reset_state: got %b want %b", {obs(1'b0), obs(1'b1)}, 10'b0);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({obs(1'b0), obs(1'b1)} !== 10'b00001_00001) begin
            failed++;
            $display("FAIL reset_release: got %b want %b", {obs(1'b0), obs(1'b1)}, 10'b00001_00001);
        end
    endtask

    task automatic test_directed();
        send_and_check(1'b0, 8'hA5, "msb_a5");
        send_and_check(1'b1, 8'h01, "lsb_01");
        send_and_check(1'b0, 8'h07, "msb_07");
        send_and_check(1'b1, 8'hA5, "lsb_a5");
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, n_acc = 0, dones = 0;
        logic got[$];
        exp_bits.delete();
        push_frame(8'hFF, 1'b1);
        push_frame(8'h00, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hFF);
        for (int c = 0; c < 40; c++) begin
            if (bv_m) got.push_back(so_m);
            if (done_m) dones++;
            if (dr_m && valid_m) begin
                if (n_acc == 1) din_m = 8'h00;
                if (n_acc == 0) first = c; else second = c;
                n_acc++;
            end
            @(negedge clk);
            if (n_acc == 2) drive(1'b0, 1'b0, W'($urandom));
            else if (n_acc == 1) din_m = W'($urandom);
        end
        tests++;
        if (second - first != int'(W + 2 + PAR) || n_acc != 2) begin
            failed++;
            $display("FAIL b2b_spacing: got %0d accepts gap %0d want 2 accepts gap %0d",
                     n_acc, second - first, W + 2 + PAR);
        end
        tests++;
        if (got != exp_bits) begin
            failed++;
            $display("FAIL b2b_bits: got %p want %p", got, exp_bits);
        end
        tests++;
        if (dones != 2) begin
            failed++;
            $display("FAIL b2b_dones: got %0d want 2", dones);
        end
    endtask

    task automatic test_reset_mid_frame();
        int dones = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (obs(1'b0) !== 5'b00000) begin
            failed++;
            $display("FAIL mid_reset_outputs: got %b want %b", obs(1'b0), 5'b00000);
        end
        reset = 1'b0;
        for (int c = 0; c < int'(W + 4); c++) begin
            if (done_m) dones++;
            @(negedge clk);
        end
        tests++;
        if (dones != 0) begin
            failed++;
            $display("FAIL mid_reset_no_done: got %0d want 0", dones);
        end
        send_and_check(1'b0, 8'h3C, "after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        logic [W-1:0] r;
        int n;
        q_bits.delete();
        sent.delete();
        mon_dones = 0;
        mon_en = 1'b1;
        for (int k = 0; k < 500; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                din_m = W'($urandom);
            end
            @(negedge clk);
            w = W'($urandom);
            drive(1'b0, 1'b1, w);
            n = 0;
            while (!dr_m && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n == 40) begin
                tests++;
                failed++;
                $display("FAIL rand_accept_timeout: word %0d got no ready in %0d cycles", k, n);
                drive(1'b0, 1'b0, '0);
                break;
            end
            sent.push_back(w);
            @(negedge clk);
            drive(1'b0, 1'b0, W'($urandom));
        end
        repeat (W + 6) @(negedge clk);
        mon_en = 1'b0;
        tests++;
        if (q_bits.size() != sent.size() * FL || mon_dones != sent.size()) begin
            failed++;
            $display("FAIL rand_counts: got %0d bits %0d dones want %0d bits %0d dones",
                     q_bits.size(), mon_dones, sent.size() * FL, sent.size());
        end else begin
            for (int k = 0; k < sent.size(); k++) begin
                r = '0;
                for (int j = 0; j < int'(W); j++) r = W'({r, q_bits[k*FL + j]});
                tests++;
                if (r !== sent[k] || (PAR != 0 && q_bits[k*FL + W] !== ^sent[k])) begin
                    failed++;
                    $display("FAIL rand_word%0d: got %h want %h", k, r, sent[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
